cpu_ctrl_sequencer: RTL and testbench

//  Multi-cycle control sequencer upstream of the ALU: fetches 16-bit instructions, decodes them and drives
//  ALU op/select/flag/carry controls and register-file addresses. Evaluates branches on ALU flag outputs
//  and owns the program counter. Flow is FETCH -> DECODE -> EXECUTE -> WRITEBACK.

---
 rtl/cpu_ctrl_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_cpu_ctrl_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl_sequencer.sv
// FETCH/DECODE/EXECUTE/WRITEBACK control sequencer for the ALU: 4 cycles per ALU op, 2 per branch/NOP, plus fetch wait.
// Fetch stalls on i_instr_valid (optional timeout -> fault/HALT); CPU_CTRL_SINGLE_STEP_EN adds an IDLE gate before each fetch.
module cpu_ctrl_sequencer #(
    parameter int                PC_W          = 8,
    parameter logic [PC_W-1:0]   RESET_PC      = '0,
    parameter int unsigned       FETCH_TIMEOUT = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    output logic             o_fetch_req,
    output logic [PC_W-1:0]  o_pc,
    input  logic             i_instr_valid,
`ifdef CPU_CTRL_SINGLE_STEP_EN
    input  logic             i_step_en,
    input  logic             i_step,
`endif
    input  logic [15:0]      i_instr,
    input  logic             i_zr,
    input  logic             i_ng,
    input  logic             i_pa,
    input  logic             i_co,
    input  logic             i_of,
    output logic [3:0]       o_alu_op,
    output logic             o_alu_sel,
    output logic             o_flag_sel,
    output logic             o_cin,
    output logic [1:0]       o_rf_raddr_a,
    output logic [1:0]       o_rf_raddr_b,
    output logic             o_imm_sel,
    output logic [7:0]       o_imm,
    output logic             o_rf_we,
    output logic [1:0]       o_rf_waddr,
    output logic             o_halted,
    output logic             o_fault
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_WRITEBACK = 3'd3,
        S_HALT      = 3'd4,
        S_IDLE      = 3'd5
    } state_t;

    localparam logic [1:0] CLS_RR  = 2'b00;
    localparam logic [1:0] CLS_RI  = 2'b01;
    localparam logic [1:0] CLS_BR  = 2'b10;

    state_t            state;
    state_t            state_nxt;
    state_t            ret_state;
    logic [PC_W-1:0]   pc;
    logic [15:0]       ir;
    logic              cin_q;
    logic              fault;
    logic [31:0]       to_cnt;
    logic              to_expire;
    logic              br_taken;
    logic [1:0]        cls;

    assign cls       = ir[15:14];
    assign to_expire = (FETCH_TIMEOUT != 0) && (to_cnt == FETCH_TIMEOUT - 1);

    always_comb begin
        case (ir[13:11])
            3'd0:    br_taken = 1'b1;
            3'd1:    br_taken = i_zr;
            3'd2:    br_taken = !i_zr;
            3'd3:    br_taken = i_co;
            3'd4:    br_taken = !i_co;
            3'd5:    br_taken = i_ng;
            3'd6:    br_taken = i_of;
            default: br_taken = i_pa;
        endcase
    end

    // Where an instruction goes once it retires: straight to FETCH unless stepping is gated.
`ifdef CPU_CTRL_SINGLE_STEP_EN
    assign ret_state = i_step_en ? S_IDLE : S_FETCH;
`else
    assign ret_state = S_FETCH;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH: begin
                if (i_instr_valid) begin
                    state_nxt = S_DECODE;
                end else if (to_expire) begin
                    state_nxt = S_HALT;
                end
            end
            S_DECODE: begin
                case (cls)
                    CLS_RR, CLS_RI: state_nxt = S_EXECUTE;
                    CLS_BR:         state_nxt = ret_state;
                    default:        state_nxt = ir[13] ? S_HALT : ret_state;
                endcase
            end
            S_EXECUTE:   state_nxt = S_WRITEBACK;
            S_WRITEBACK: state_nxt = ret_state;
            S_HALT:      state_nxt = S_HALT;
`ifdef CPU_CTRL_SINGLE_STEP_EN
            S_IDLE: begin
                if (!i_step_en || i_step) begin
                    state_nxt = S_FETCH;
                end
            end
`endif
            default:     state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc     <= RESET_PC;
            ir     <= '0;
            cin_q  <= 1'b0;
            fault  <= 1'b0;
            to_cnt <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (i_instr_valid) begin
                        ir     <= i_instr;
                        pc     <= pc + PC_W'(1);
                        to_cnt <= '0;
                    end else if (to_expire) begin
                        fault  <= 1'b1;
                        to_cnt <= '0;
                    end else begin
                        to_cnt <= to_cnt + 32'd1;
                    end
                end
                S_DECODE: begin
                    cin_q <= i_co;
                    if (cls == CLS_BR && br_taken) begin
                        pc <= PC_W'(ir[7:0]);
                    end
                end
                default: to_cnt <= '0;
            endcase
        end
    end

    assign o_pc    = pc;
    assign o_fault = fault;

    // Strobes are masked by i_rst so an aborted instruction never pulses into the ALU or reg file.
    always_comb begin
        o_fetch_req  = 1'b0;
        o_halted     = 1'b0;
        o_alu_op     = 4'd0;
        o_alu_sel    = 1'b0;
        o_flag_sel   = 1'b0;
        o_cin        = 1'b0;
        o_rf_raddr_a = 2'd0;
        o_rf_raddr_b = 2'd0;
        o_imm_sel    = 1'b0;
        o_imm        = 8'd0;
        o_rf_we      = 1'b0;
        o_rf_waddr   = 2'd0;
        case (state)
            S_FETCH: o_fetch_req = 1'b1;
            S_HALT:  o_halted    = 1'b1;
            S_DECODE, S_EXECUTE, S_WRITEBACK: begin
                o_rf_raddr_a = ir[9:8];
                o_rf_raddr_b = ir[7:6];
                o_imm        = ir[7:0];
                o_imm_sel    = (cls == CLS_RI);
                if (state == S_EXECUTE) begin
                    o_alu_sel  = !i_rst;
                    o_alu_op   = ir[13:10];
                    o_cin      = cin_q;
                    o_flag_sel = !i_rst && ((cls == CLS_RI) || ir[0]);
                end
                if (state == S_WRITEBACK) begin
                    o_rf_we    = !i_rst;
                    o_rf_waddr = ir[9:8];
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_ctrl_sequencer.sv
// Directed bench for cpu_ctrl_sequencer built with FETCH_TIMEOUT=4; inputs change and outputs are checked on the falling edge.
module tb_cpu_ctrl_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [7:0]  pc;
    logic        instr_valid;
    logic [15:0] instr;
    logic        zr, ng, pa, co, of_f;
    logic [3:0]  alu_op;
    logic        alu_sel, flag_sel, cin;
    logic [1:0]  raddr_a, raddr_b;
    logic        imm_sel;
    logic [7:0]  imm;
    logic        rf_we;
    logic [1:0]  waddr;
    logic        halted, fault;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cpu_ctrl_sequencer #(.PC_W(8), .RESET_PC(8'h00), .FETCH_TIMEOUT(4)) dut (
        .i_clk(clk), .i_rst(rst), .o_fetch_req(fetch_req), .o_pc(pc),
        .i_instr_valid(instr_valid), .i_instr(instr),
        .i_zr(zr), .i_ng(ng), .i_pa(pa), .i_co(co), .i_of(of_f),
        .o_alu_op(alu_op), .o_alu_sel(alu_sel), .o_flag_sel(flag_sel), .o_cin(cin),
        .o_rf_raddr_a(raddr_a), .o_rf_raddr_b(raddr_b), .o_imm_sel(imm_sel), .o_imm(imm),
        .o_rf_we(rf_we), .o_rf_waddr(waddr), .o_halted(halted), .o_fault(fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nc();
        @(negedge clk);
    endtask

    // One ALU instruction from a FETCH-state falling edge back to the next FETCH.
    task automatic alu_instr(input logic [15:0] ins, input logic c_in, input logic [7:0] pc_exp,
                             input logic [1:0] rd, input logic [1:0] rs, input logic isel,
                             input logic [3:0] op, input logic fsel);
        chk("alu_fetch_req", fetch_req, 1);
        instr_valid = 1'b1; instr = ins;
        nc();
        instr_valid = 1'b0;
        chk("dec_fetch_req", fetch_req, 0);
        chk("dec_pc", pc, pc_exp);
        chk("dec_raddr_a", raddr_a, rd);
        chk("dec_raddr_b", raddr_b, rs);
        chk("dec_imm_sel", imm_sel, isel);
        chk("dec_imm", imm, ins[7:0]);
        chk("dec_alu_sel", alu_sel, 0);
        co = c_in;
        nc();
        co = 1'b0;
        chk("ex_alu_sel", alu_sel, 1);
        chk("ex_alu_op", alu_op, op);
        chk("ex_flag_sel", flag_sel, fsel);
        chk("ex_cin", cin, c_in);
        chk("ex_rf_we", rf_we, 0);
        nc();
        chk("wb_rf_we", rf_we, 1);
        chk("wb_waddr", waddr, rd);
        chk("wb_alu_sel", alu_sel, 0);
        chk("wb_flag_sel", flag_sel, 0);
        nc();
        chk("ret_fetch_req", fetch_req, 1);
        chk("ret_rf_we", rf_we, 0);
    endtask

    // Branch or NOP: DECODE then straight back to FETCH; flags = {zr,ng,pa,co,of}.
    task automatic two_cyc(input logic [15:0] ins, input logic [4:0] flags, input logic [7:0] pc_exp);
        {zr, ng, pa, co, of_f} = flags;
        instr_valid = 1'b1; instr = ins;
        nc();
        instr_valid = 1'b0;
        chk("br_dec_fetch_req", fetch_req, 0);
        chk("br_dec_alu_sel", alu_sel, 0);
        nc();
        {zr, ng, pa, co, of_f} = 5'b0;
        chk("br_fetch_req", fetch_req, 1);
        chk("br_pc", pc, pc_exp);
        chk("br_rf_we", rf_we, 0);
    endtask

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr = 16'h0000;
        {zr, ng, pa, co, of_f} = 5'b0;
        nc(); nc();
        rst = 1'b0;
        nc();
        chk("rst_pc", pc, 8'h00);
        chk("rst_fetch_req", fetch_req, 1);
        chk("rst_alu_sel", alu_sel, 0);
        chk("rst_flag_sel", flag_sel, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_halted", halted, 0);
        chk("rst_fault", fault, 0);

        // RR add r1,r2 with flag update; RI op5 r3,#3C; RR without flag update.
        alu_instr(16'h0981, 1'b1, 8'h01, 2'd1, 2'd2, 1'b0, 4'h2, 1'b1);
        alu_instr(16'h573C, 1'b0, 8'h02, 2'd3, 2'd0, 1'b1, 4'h5, 1'b1);
        alu_instr(16'h0980, 1'b0, 8'h03, 2'd1, 2'd2, 1'b0, 4'h2, 1'b0);

        two_cyc(16'h8814, 5'b10000, 8'h14);   // Z taken
        two_cyc(16'h8814, 5'b00000, 8'h15);   // Z not taken
        two_cyc(16'hA020, 5'b00010, 8'h16);   // !C with C=1, not taken
        two_cyc(16'hB040, 5'b00001, 8'h40);   // V taken
        two_cyc(16'h80FF, 5'b00000, 8'hFF);   // always
        two_cyc(16'hC000, 5'b00000, 8'h00);   // NOP wraps PC

        // Valid arriving on the 4th fetch cycle is accepted without fault.
        nc(); nc(); nc();
        chk("to4_fetch_req", fetch_req, 1);
        chk("to4_fault_pre", fault, 0);
        instr_valid = 1'b1; instr = 16'hC000;
        nc();
        instr_valid = 1'b0;
        chk("to4_decode", fetch_req, 0);
        chk("to4_fault", fault, 0);
        chk("to4_halted", halted, 0);
        nc();
        chk("to4_pc", pc, 8'h01);

        // Reset during EXECUTE aborts the instruction.
        instr_valid = 1'b1; instr = 16'h0981;
        nc();
        instr_valid = 1'b0;
        nc();
        chk("abort_ex_alu_sel", alu_sel, 1);
        rst = 1'b1;
        nc();
        chk("abort_rf_we", rf_we, 0);
        chk("abort_pc", pc, 8'h00);
        chk("abort_alu_sel", alu_sel, 0);
        rst = 1'b0;
        nc();
        chk("abort_rf_we2", rf_we, 0);
        chk("abort_fetch_req", fetch_req, 1);

        // HALT holds with no fetch requests, ignoring valid.
        instr_valid = 1'b1; instr = 16'hE000;
        nc();
        instr_valid = 1'b0;
        nc();
        chk("halt_halted", halted, 1);
        instr_valid = 1'b1; instr = 16'h0981;
        for (int i = 0; i < 20; i++) begin
            nc();
            chk("halt_fetch_req", fetch_req, 0);
        end
        chk("halt_still", halted, 1);
        chk("halt_no_we", rf_we, 0);
        instr_valid = 1'b0;

        // Fetch timeout: four cycles without valid -> fault and HALT.
        rst = 1'b1;
        nc();
        rst = 1'b0;
        chk("to_rst_halted", halted, 0);
        nc(); nc(); nc();
        chk("to_fault_pre", fault, 0);
        chk("to_halted_pre", halted, 0);
        nc();
        chk("to_fault", fault, 1);
        chk("to_halted", halted, 1);
        chk("to_fetch_req", fetch_req, 0);
        nc();
        chk("to_fault_sticky", fault, 1);
        rst = 1'b1;
        nc();
        rst = 1'b0;
        chk("to_fault_cleared", fault, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
